fill_scheduler: RTL and testbench



---
 rtl/fill_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 15 +
 rtl/fill_scheduler.sv | 139 +++++++++++++
 tb/tb_fill_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared types and coordinate layout for the fill path (scheduler, fill_wrapper, rasterizer).
package fill_pkg;
  localparam int X_START_LSB = 36;
  localparam int Y_START_LSB = 24;
  localparam int X_END_LSB   = 12;
  localparam int Y_END_LSB   = 0;

  typedef struct packed {
    logic [47:0] coords;
    logic [23:0] color;
    logic [1:0]  texture;
    logic        fill_type;
    logic        layer;
  } fill_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE
  } fill_sched_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  always_comb begin
    gnt_idx = ~last_grant;
    if (req == 2'b01)      gnt_idx = 1'b0;
    else if (req == 2'b10) gnt_idx = 1'b1;
    gnt = '0;
    if (|req) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/fill_scheduler.sv
// Arbitrates two requesters onto one fill_wrapper: capture, bbox check, issue, wait with watchdog, complete.
module fill_scheduler
  import fill_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int COORD_W        = 12,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int CNT_W          = 20
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0][47:0]     req_coordinates,
  input  logic [NUM_REQ-1:0][23:0]     req_color_code,
  input  logic [NUM_REQ-1:0][1:0]      req_texture_code,
  input  logic [NUM_REQ-1:0]           req_fill_type,
  input  logic [NUM_REQ-1:0]           req_layer_num,
  output logic [NUM_REQ-1:0]           cmp_valid,
  output logic                         cmp_err,
  output logic                         fill_en,
  input  logic                         fill_done,
  output logic [47:0]                  coordinates,
  output logic [23:0]                  color_code,
  output logic [1:0]                   texture_code,
  output logic                         fill_type,
  output logic                         layer_num,
  output logic                         busy,
  output logic                         err_timeout,
  input  logic                         err_clr
);
  fill_sched_state_t state_q, state_d;
  fill_cmd_t         cmd_q, cmd_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              err_q, err_d;
  logic              err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]  wd_q, wd_d;

  logic [1:0]        gnt;
  logic              gnt_idx;
  logic [COORD_W-1:0] xs, ys, xe, ye;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign xs = cmd_q.coords[X_START_LSB +: COORD_W];
  assign ys = cmd_q.coords[Y_START_LSB +: COORD_W];
  assign xe = cmd_q.coords[X_END_LSB   +: COORD_W];
  assign ye = cmd_q.coords[Y_END_LSB   +: COORD_W];

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    err_d         = err_q;
    wd_d          = wd_q;
    err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (|(req_valid & req_ready)) begin
          cmd_d.coords    = req_coordinates[gnt_idx];
          cmd_d.color     = req_color_code[gnt_idx];
          cmd_d.texture   = req_texture_code[gnt_idx];
          cmd_d.fill_type = req_fill_type[gnt_idx];
          cmd_d.layer     = req_layer_num[gnt_idx];
          owner_d         = gnt_idx;
          last_grant_d    = gnt_idx;
          state_d         = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((xs > xe) || (ys > ye)) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a coincident watchdog expiry
        if (fill_done) begin
          err_d   = 1'b0;
          state_d = S_COMPLETE;
        end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d         = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = S_COMPLETE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      err_q         <= 1'b0;
      err_timeout_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      err_q         <= err_d;
      err_timeout_q <= err_timeout_d;
      wd_q          <= wd_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE) ? gnt : '0;
  assign fill_en      = (state_q == S_ISSUE);
  assign cmp_valid    = (state_q == S_COMPLETE) ? (2'b01 << owner_q) : '0;
  assign cmp_err      = (state_q == S_COMPLETE) & err_q;
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = err_timeout_q;
  assign coordinates  = cmd_q.coords;
  assign color_code   = cmd_q.color;
  assign texture_code = cmd_q.texture;
  assign fill_type    = cmd_q.fill_type;
  assign layer_num    = cmd_q.layer;
endmodule

// File: tb/tb_fill_scheduler.sv
// Randomized bench for fill_scheduler against a transaction-level model of grant, latency and status.
module tb_fill_scheduler;
  localparam int T = 32;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][47:0] req_coordinates;
  logic [1:0][23:0] req_color_code;
  logic [1:0][1:0]  req_texture_code;
  logic [1:0]       req_fill_type;
  logic [1:0]       req_layer_num;
  logic [1:0]       cmp_valid;
  logic             cmp_err;
  logic             fill_en;
  logic             fill_done;
  logic [47:0]      coordinates;
  logic [23:0]      color_code;
  logic [1:0]       texture_code;
  logic             fill_type;
  logic             layer_num;
  logic             busy;
  logic             err_timeout;
  logic             err_clr;

  int vectors = 0;
  int miscompares = 0;
  int last_m = 1;
  logic err_m = 1'b0;

  fill_scheduler #(.NUM_REQ(2), .COORD_W(12), .TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_coordinates(req_coordinates), .req_color_code(req_color_code),
    .req_texture_code(req_texture_code), .req_fill_type(req_fill_type),
    .req_layer_num(req_layer_num),
    .cmp_valid(cmp_valid), .cmp_err(cmp_err),
    .fill_en(fill_en), .fill_done(fill_done),
    .coordinates(coordinates), .color_code(color_code),
    .texture_code(texture_code), .fill_type(fill_type), .layer_num(layer_num),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh(input int w);
    return (w != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int r);
    logic [11:0] a, b, c, d, t;
    a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); d = 12'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      if (a > b) begin t = a; a = b; b = t; end
      if (c > d) begin t = c; c = d; d = t; end
    end
    req_coordinates[r]  = {a, c, b, d};
    req_color_code[r]   = 24'($urandom);
    req_texture_code[r] = 2'($urandom);
    req_fill_type[r]    = 1'($urandom);
    req_layer_num[r]    = 1'($urandom);
  endtask

  // d = WAIT cycle (1-based) in which done pulses, 0 = never; held = done stuck high throughout
  task automatic transact(input logic [1:0] vmask, input int d, input bit held);
    int w, deff, exp_c;
    logic rej, exp_err, tmo;
    logic [47:0] co;
    w = (vmask == 2'b11) ? ((last_m != 0) ? 0 : 1) : (vmask[1] ? 1 : 0);
    req_valid = vmask;
    fill_done = held;
    #1;
    for (int k = 0; k < 4 && !(|(req_ready & req_valid)); k++) tick();
    vectors++;
    if (req_ready !== oh(w)) begin
      miscompares++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, oh(w));
      req_valid = 2'b00;
      return;
    end
    tick();
    req_valid = 2'b00;
    last_m = w;
    co = req_coordinates[w];
    rej = (co[47:36] > co[23:12]) || (co[35:24] > co[11:0]);
    deff = held ? 1 : d;
    tmo = 1'b0;
    if (rej) begin exp_c = 2; exp_err = 1'b1; end
    else if (deff == 0 || deff > T) begin exp_c = 3 + T; exp_err = 1'b1; tmo = 1'b1; end
    else begin exp_c = 3 + deff; exp_err = 1'b0; end
    for (int c = 1; c <= exp_c + 1; c++) begin
      if (c == exp_c && tmo) err_m = 1'b1;
      vectors++;
      if (fill_en !== (c == 2 && !rej)) begin
        miscompares++;
        $display("FAIL fill_en: cycle %0d got %b expected %b", c, fill_en, (c == 2 && !rej));
      end
      vectors++;
      if (cmp_valid !== ((c == exp_c) ? oh(w) : 2'b00) ||
          cmp_err !== ((c == exp_c) ? exp_err : 1'b0)) begin
        miscompares++;
        $display("FAIL completion: cycle %0d cmp_valid=%b cmp_err=%b expected cycle %0d valid=%b err=%b",
                 c, cmp_valid, cmp_err, exp_c, oh(w), exp_err);
      end
      vectors++;
      if (busy !== (c <= exp_c) || err_timeout !== err_m) begin
        miscompares++;
        $display("FAIL status: cycle %0d busy=%b err_timeout=%b expected %b %b",
                 c, busy, err_timeout, (c <= exp_c), err_m);
      end
      if (c == 2) begin
        vectors++;
        if (coordinates !== co || color_code !== req_color_code[w] ||
            texture_code !== req_texture_code[w] || fill_type !== req_fill_type[w] ||
            layer_num !== req_layer_num[w]) begin
          miscompares++;
          $display("FAIL fields: got %h %h %h %b %b expected %h %h %h %b %b",
                   coordinates, color_code, texture_code, fill_type, layer_num,
                   co, req_color_code[w], req_texture_code[w], req_fill_type[w], req_layer_num[w]);
        end
      end
      fill_done = held ? 1'b1 : (d > 0 && c == 2 + d);
      if (c <= exp_c) tick();
    end
    if (!held) fill_done = 1'b0;
  endtask

  task automatic check_idle_zero(input string nm);
    vectors++;
    if (req_ready !== 2'b00 || cmp_valid !== 2'b00 || cmp_err !== 1'b0 || fill_en !== 1'b0 ||
        busy !== 1'b0 || err_timeout !== 1'b0 || coordinates !== 48'h0 || color_code !== 24'h0 ||
        texture_code !== 2'b00 || fill_type !== 1'b0 || layer_num !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: rdy=%b cv=%b ce=%b en=%b busy=%b et=%b co=%h col=%h expected all zero",
               nm, req_ready, cmp_valid, cmp_err, fill_en, busy, err_timeout, coordinates, color_code);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_valid = 2'b00; fill_done = 1'b0; err_clr = 1'b0;
    req_coordinates = '0; req_color_code = '0; req_texture_code = '0;
    req_fill_type = '0; req_layer_num = '0;
    repeat (3) tick();
    check_idle_zero("reset");
    n_rst = 1'b1;
    tick();
    check_idle_zero("post_reset_idle");
    last_m = 1; err_m = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      gen(0); gen(1);
      req_coordinates[0] = 48'h001_002_010_020;
      req_coordinates[1] = 48'h003_004_030_040;
      transact(2'b11, $urandom_range(1, 5), 1'b0);
      vectors++;
      if (last_m !== (i % 2)) begin
        miscompares++;
        $display("FAIL rr_order: grant %0d went to %0d expected %0d", i, last_m, i % 2);
      end
    end
  endtask

  task automatic test_single();
    req_coordinates[0] = 48'h000_000_00F_00F; req_color_code[0] = 24'hFF0000;
    req_texture_code[0] = 2'b10; req_fill_type[0] = 1'b1; req_layer_num[0] = 1'b0;
    transact(2'b01, 20, 1'b0);
  endtask

  task automatic test_reject();
    req_coordinates[1] = {12'h0C8, 12'h000, 12'h064, 12'h0FF};
    req_color_code[1] = 24'h00FF00;
    transact(2'b10, 5, 1'b0);
  endtask

  task automatic test_timeout();
    req_coordinates[0] = 48'h010_010_020_020;
    transact(2'b01, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (err_timeout !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_sticky: err_timeout=%b expected 1", err_timeout);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m = 1'b0;
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: err_timeout=%b expected 0", err_timeout);
    end
  endtask

  task automatic test_stale_done();
    gen(0); gen(1);
    req_coordinates[0] = 48'h005_005_050_050;
    req_coordinates[1] = 48'h006_006_060_060;
    transact(2'b01, 0, 1'b1);
    transact(2'b10, 0, 1'b1);
    fill_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    gen(1);
    req_coordinates[1] = 48'h001_001_100_100;
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = 2'b00;
    repeat (5) tick();
    vectors++;
    if (busy !== 1'b1 || fill_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_wait_busy: busy=%b fill_en=%b expected 1 0", busy, fill_en);
    end
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    last_m = 1; err_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle_zero("mid_wait_reset");
      tick();
    end
    gen(0); gen(1);
    req_coordinates[0] = 48'h002_002_020_020;
    transact(2'b11, 3, 1'b0);
    vectors++;
    if (last_m !== 0) begin
      miscompares++;
      $display("FAIL post_reset_grant: winner %0d expected 0", last_m);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int d, m;
      logic [1:0] vm;
      gen(0); gen(1);
      m = $urandom_range(0, 9);
      d = (m == 0) ? 0 : (m == 1) ? $urandom_range(T - 1, T + 2) : $urandom_range(1, 12);
      vm = 2'($urandom_range(1, 3));
      transact(vm, d, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m = 1'b0;
        vectors++;
        if (err_timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_clear: err_timeout=%b expected 0", err_timeout);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_reject();
    test_timeout();
    test_stale_done();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
